// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID pipeline register.
// Holds the PC and a loadable instruction memory, and presents one decoded
// instruction per unstalled cycle. Handles stall, branch redirect and halt.
module if_fetch_unit #(
   parameter int unsigned IMEM_DEPTH = 32,
   parameter int unsigned PC_W       = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   input  logic            imem_we,
   input  logic [PC_W-1:0] imem_waddr,
   input  logic [15:0]     imem_wdata,
   output logic            out_valid,
   output logic [2:0]      out_opcode,
   output logic [4:0]      out_ad1,
   output logic [7:0]      out_imm,
   output logic [PC_W-1:0] out_pc,
   output logic            halted
);

   localparam logic [2:0] OpHalt = 3'b111;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StHalt
   } state_e;

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            valid_q, valid_d;
   logic [2:0]      opcode_q, opcode_d;
   logic [4:0]      ad1_q, ad1_d;
   logic [7:0]      imm_q, imm_d;
   logic [PC_W-1:0] out_pc_q, out_pc_d;

   logic [15:0]     mem [IMEM_DEPTH];
   logic [15:0]     fetch_word;

   // Combinational read; a same-cycle write lands after this edge, so the old word is fetched.
   assign fetch_word = mem[pc_q];

   // Synchronous write port, open in every state; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (imem_we) begin
         mem[imem_waddr] <= imem_wdata;
      end
   end

   // Next-state: redirect beats stall, stall beats fetch; a fetched halt opcode enters HALT.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      valid_d  = valid_q;
      opcode_d = opcode_q;
      ad1_d    = ad1_q;
      imm_d    = imm_q;
      out_pc_d = out_pc_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               pc_d    = '0;
            end
         end
         StRun: begin
            if (redirect_valid) begin
               pc_d    = redirect_pc;
               valid_d = 1'b0;
            end else if (!stall) begin
               opcode_d = fetch_word[15:13];
               ad1_d    = fetch_word[12:8];
               imm_d    = fetch_word[7:0];
               out_pc_d = pc_q;
               valid_d  = 1'b1;
               pc_d     = pc_q + 1'b1;
               if (fetch_word[15:13] == OpHalt) begin
                  state_d = StHalt;
               end
            end
         end
         StHalt: begin
            if (start) begin
               state_d = StRun;
               pc_d    = '0;
               valid_d = 1'b0;
            end else if (!stall) begin
               // The halt instruction stays offered through a stall, then drops.
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers; reset discards any in-flight instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         pc_q     <= '0;
         valid_q  <= 1'b0;
         opcode_q <= '0;
         ad1_q    <= '0;
         imm_q    <= '0;
         out_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         valid_q  <= valid_d;
         opcode_q <= opcode_d;
         ad1_q    <= ad1_d;
         imm_q    <= imm_d;
         out_pc_q <= out_pc_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_opcode = opcode_q;
   assign out_ad1    = ad1_q;
   assign out_imm    = imm_q;
   assign out_pc     = out_pc_q;
   assign halted     = (state_q == StHalt);

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage that drives the IF/ID pipeline register. It holds a program counter and a small loadable instruction memory. Each cycle it presents one decoded instruction field set (opcode, ad1, imm) with a valid flag, and it honours stall, branch redirect and halt. Its outputs connect directly to the IF/ID register inputs (in_valid, in_opcode, in_ad1, in_imm). The shared stall signal drives both blocks.

## Interface
- IMEM_DEPTH, 32: instruction memory words; must equal 2^PC_W.
- PC_W, 5: program counter width.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin fetching at PC 0; sampled in IDLE or HALT only.
- stall  in  1  freeze fetch (same signal fed to IF/ID register).
- redirect_valid  in  1  branch/jump taken; load redirect_pc.
- redirect_pc  in  PC_W  redirect target.
- imem_we  in  1  instruction memory write enable.
- imem_waddr  in  PC_W  write address.
- imem_wdata  in  16  instruction word: [15:13] opcode, [12:8] ad1, [7:0] imm.
- out_valid  out  1  instruction on out_* is valid.
- out_opcode  out  3  instruction bits [15:13].
- out_ad1  out  5  instruction bits [12:8].
- out_imm  out  8  instruction bits [7:0].
- out_pc  out  PC_W  address of the instruction on out_*.
- halted  out  1  high while in HALT.

## Operation
- Memory: IMEM_DEPTH x 16 array with combinational read at pc and a synchronous write port. Memory contents are not reset. A write and a fetch to the same address in the same cycle: the fetch returns the old word.
- FSM states:
  - IDLE (reset state): out_valid=0, pc=0. start → RUN.
  - RUN: fetch.
  - HALT: out_valid=0, halted=1. start → RUN with pc=0.
- RUN per cycle, in priority order:
  1. redirect_valid: pc<=redirect_pc, out_valid<=0 (one bubble), out_* fields hold. Redirect wins over stall.
  2. stall: pc and all out_* hold, including out_valid. The IF/ID register inserts its own bubble, so the held instruction is re-offered after the stall.
  3. Otherwise: out_*<=fields of mem[pc], out_pc<=pc, out_valid<=1, pc<=pc+1. PC wraps modulo IMEM_DEPTH (IMEM_DEPTH-1 → 0).
- Halt: when a word with opcode 3'b111 is registered onto out_* (valid=1), the FSM goes to HALT in the same edge. The HALT instruction is itself delivered once and held through any stall. The next non-stalled cycle drops out_valid to 0. halted rises on the same edge.
- start while in RUN is ignored. redirect_valid in IDLE or HALT is ignored.
- imem writes are accepted in every state.

## Timing
- Reset values: out_valid=0, out_opcode=0, out_ad1=0, out_imm=0, out_pc=0, halted=0, pc=0, state=IDLE.
- Reset is asynchronous mid-operation: all of the above apply immediately. An in-flight instruction is discarded.
- Latency: start at edge N puts mem[0] on out_* with out_valid=1 after edge N+1. After that, one instruction per unstalled cycle.
- Redirect at edge N: out_valid=0 after edge N. mem[redirect_pc] appears after edge N+1.
- A stall held for K cycles holds outputs for exactly K cycles. Fetch resumes on the first cycle with stall low.

## Test plan
- Load mem[0..3] = 0x2105, 0x4210, 0x6320, 0xE000, then pulse start → out_valid high for 4 consecutive cycles with out_opcode 1,2,3,7, out_ad1 1,2,3,0, out_imm 0x05,0x10,0x20,0x00, out_pc 0..3. Next cycle out_valid=0 and halted=1.
- During the run, assert stall for 2 cycles while out_pc=1 → out_* hold at pc 1 with out_valid=1. pc 2 appears one cycle after stall drops, with no skipped or duplicated PC.
- Assert redirect_valid with redirect_pc=0x1E, together with stall, while at pc 2 → next cycle out_valid=0. Then out_pc=0x1E, then 0x1F, then 0x00 (wrap).
- Assert rst while out_valid=1 mid-run → all outputs zero immediately. State is IDLE and no fetch occurs until start.
- Write 0xA0FF to address 5 in the same cycle that pc=5 is fetched → the old word is delivered. A refetch via redirect to 5 returns opcode 5, ad1 0, imm 0xFF.
- Assert start in HALT → restart from pc 0 and halted drops on the same edge.
